// File: rtl/prog_dumper_pkg.sv
// Shared definitions for the program dumper and its UART transmitter.
// CLK_DIV default is common with the program loader so both ends agree on baud.
package prog_dumper_pkg;

   localparam int UART_BITS         = 10;
   localparam int CLK_DIV_DEFAULT   = 104;
   localparam int READ_WAIT_DEFAULT = 3;
   localparam int ADR_W_DEFAULT     = 21;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_SEND = 3'd2,
      ST_NEXT = 3'd3,
      ST_FIN  = 3'd4
   } dump_state_t;

endpackage

// File: rtl/prog_dumper_uart_tx.sv
// 8N1 UART transmitter: go starts a frame whose start bit appears the next cycle.
// busy covers exactly the 10 bit periods of the frame.
module uart_tx
   import prog_dumper_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       go,
   input  logic [7:0] data_byte,
   output logic       busy,
   output logic       tx
);

   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [3:0] BIT_LAST = 4'(UART_BITS - 1);

   logic [BAUD_W-1:0] baud_cnt_reg;
   logic [3:0]        bit_cnt_reg;
   logic [8:0]        shift_reg;
   logic              busy_reg;
   logic              tx_reg;

   // shift_reg holds the 8 data bits followed by the stop bit; the start bit
   // is driven directly when the frame is launched.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '1;
         busy_reg     <= 1'b0;
         tx_reg       <= 1'b1;
      end else if (!busy_reg) begin
         if (go) begin
            busy_reg     <= 1'b1;
            tx_reg       <= 1'b0;
            shift_reg    <= {1'b1, data_byte};
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
         end
      end else if (baud_cnt_reg == BAUD_LAST) begin
         baud_cnt_reg <= '0;
         if (bit_cnt_reg == BIT_LAST) begin
            busy_reg    <= 1'b0;
            tx_reg      <= 1'b1;
            bit_cnt_reg <= '0;
         end else begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b1, shift_reg[8:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
         end
      end else begin
         baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
      end
   end

   assign busy = busy_reg;
   assign tx   = tx_reg;

endmodule

// File: rtl/prog_dumper.sv
// Streams memory range [adr_first, adr_last] out over UART for host-side readback.
// Read-only bus master: drives adr and read, never data or write.
module prog_dumper
   import prog_dumper_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEFAULT,
   parameter int READ_WAIT = READ_WAIT_DEFAULT,
   parameter int ADR_W     = ADR_W_DEFAULT
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start,
   input  logic [ADR_W-1:0] adr_first,
   input  logic [ADR_W-1:0] adr_last,
   output logic [ADR_W-1:0] adr,
   input  logic [7:0]       data,
   output logic             read,
   output logic             busy,
   output logic             done,
   output logic             tx
);

   localparam int WAIT_W = $clog2(READ_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

   dump_state_t       state_reg, state_next;
   logic [ADR_W-1:0]  cur_reg, cur_next;
   logic [ADR_W-1:0]  end_reg, end_next;
   logic [ADR_W-1:0]  adr_hold_reg;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic [7:0]        byte_reg, byte_next;
   logic              sent_reg, sent_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              tx_go;
   logic              tx_busy;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_reg    <= ST_IDLE;
         cur_reg      <= '0;
         end_reg      <= '0;
         adr_hold_reg <= '0;
         wait_cnt_reg <= '0;
         byte_reg     <= '0;
         sent_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cur_reg      <= cur_next;
         end_reg      <= end_next;
         wait_cnt_reg <= wait_cnt_next;
         byte_reg     <= byte_next;
         sent_reg     <= sent_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         if (state_reg == ST_RD) begin
            adr_hold_reg <= cur_reg;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cur_next      = cur_reg;
      end_next      = end_reg;
      wait_cnt_next = wait_cnt_reg;
      byte_next     = byte_reg;
      sent_next     = sent_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      tx_go         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               cur_next      = adr_first;
               end_next      = adr_last;
               busy_next     = 1'b1;
               wait_cnt_next = '0;
               state_next    = (adr_last < adr_first) ? ST_FIN : ST_RD;
            end
         end
         ST_RD: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               byte_next  = data;
               sent_next  = 1'b0;
               state_next = ST_SEND;
            end else begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
         end
         ST_SEND: begin
            // First SEND cycle launches the frame; afterwards wait for it to drain.
            if (!sent_reg) begin
               tx_go     = 1'b1;
               sent_next = 1'b1;
            end else if (!tx_busy) begin
               state_next = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // Compare before incrementing so the top address never wraps.
            if (cur_reg == end_reg) begin
               state_next = ST_FIN;
            end else begin
               cur_next      = cur_reg + ADR_W'(1);
               wait_cnt_next = '0;
               state_next    = ST_RD;
            end
         end
         ST_FIN: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign read = (state_reg == ST_RD);
   assign adr  = read ? cur_reg : adr_hold_reg;
   assign busy = busy_reg;
   assign done = done_reg;

   uart_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_uart_tx (
      .clk       (clk),
      .n_reset   (n_reset),
      .go        (tx_go),
      .data_byte (byte_reg),
      .busy      (tx_busy),
      .tx        (tx)
   );

endmodule

// File: tb/tb_prog_dumper.sv
// Randomised and directed checks of prog_dumper against a UART-decoding memory
// reference: every byte on tx must equal adr^0xA5 for each address of the range.
module tb_prog_dumper;

   localparam int CD       = 4;
   localparam int RW       = 2;
   localparam int AW       = 21;
   localparam int FRAME    = 10 * CD;
   localparam int BYTE_CYC = RW + FRAME + 3;
   localparam logic [AW-1:0] ADR_MAX = '1;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] adr_first = '0;
   logic [AW-1:0] adr_last = '0;
   logic [AW-1:0] adr;
   logic [7:0]    data;
   logic          read;
   logic          busy;
   logic          done;
   logic          tx;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   assign data = mem_byte(adr);

   prog_dumper #(
      .CLK_DIV   (CD),
      .READ_WAIT (RW),
      .ADR_W     (AW)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (start),
      .adr_first (adr_first),
      .adr_last  (adr_last),
      .adr       (adr),
      .data      (data),
      .read      (read),
      .busy      (busy),
      .done      (done),
      .tx        (tx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bus and line observers: decode UART frames, log read bursts, count done cycles.
   int            cyc = 0;
   int            done_cnt = 0;
   int            adr_unstable = 0;
   bit            adr_zero_seen = 1'b0;
   logic [7:0]    rx_q[$];
   int            fs_q[$];
   logic [AW-1:0] rd_adr_q[$];
   int            rd_len_q[$];
   bit            in_frame;
   int            rx_k;
   logic          prev_tx;
   logic          prev_read;
   int            rd_len;
   logic          smp[FRAME];
   logic [7:0]    rx_byte;
   int            shape;

   initial begin
      in_frame  = 1'b0;
      rx_k      = 0;
      prev_tx   = 1'b1;
      prev_read = 1'b0;
      rd_len    = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!n_reset) begin
            in_frame  = 1'b0;
            prev_tx   = 1'b1;
            prev_read = 1'b0;
            rd_len    = 0;
         end else begin
            if (done) done_cnt++;
            if (adr == '0) adr_zero_seen = 1'b1;
            if (read) begin
               if (!prev_read) begin
                  rd_adr_q.push_back(adr);
                  rd_len = 0;
               end else if (adr !== rd_adr_q[$]) begin
                  adr_unstable++;
               end
               rd_len++;
            end else if (prev_read) begin
               rd_len_q.push_back(rd_len);
            end
            prev_read = read;
            if (in_frame) begin
               smp[rx_k] = tx;
               rx_k++;
               if (rx_k == FRAME) begin
                  shape = 0;
                  for (int bi = 0; bi < 10; bi++)
                     for (int j = 1; j < CD; j++)
                        if (smp[bi*CD+j] !== smp[bi*CD]) shape++;
                  check("frame_bit_width", shape, 0);
                  check("frame_start_stop", {30'd0, smp[0], smp[9*CD]}, 32'd1);
                  for (int i = 0; i < 8; i++) rx_byte[i] = smp[(i+1)*CD];
                  rx_q.push_back(rx_byte);
                  in_frame = 1'b0;
               end
            end else if (prev_tx && !tx) begin
               in_frame = 1'b1;
               smp[0]   = tx;
               rx_k     = 1;
               fs_q.push_back(cyc);
            end
            prev_tx = tx;
         end
      end
   end

   // Called at a negedge; drives start for one cycle and checks the whole transfer.
   task automatic run_xfer(input logic [AW-1:0] f, input logic [AW-1:0] l, input string name,
                           input int poke_at, input int tail);
      logic [AW-1:0] exp_adr[$];
      logic [AW-1:0] a;
      int n;
      int budget;
      int d0;
      if (l >= f) begin
         a = f;
         forever begin
            exp_adr.push_back(a);
            if (a == l) break;
            a++;
         end
      end
      rx_q.delete();
      fs_q.delete();
      rd_adr_q.delete();
      rd_len_q.delete();
      adr_unstable  = 0;
      adr_zero_seen = 1'b0;
      d0 = done_cnt;
      adr_first = f;
      adr_last  = l;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      budget = exp_adr.size() * BYTE_CYC + 20;
      n = 0;
      while (!done && n < budget) begin
         if (n == poke_at) begin
            adr_first = 21'h00300;
            adr_last  = 21'h00305;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("done_in_time", (n < budget) ? 32'd1 : 32'd0, 1);
      check("busy_at_done", busy, 0);
      if (exp_adr.size() == 0) check("empty_done_latency", n, 1);
      check("byte_count", rx_q.size(), exp_adr.size());
      for (int i = 0; i < exp_adr.size() && i < rx_q.size(); i++)
         check("byte_value", rx_q[i], mem_byte(exp_adr[i]));
      check("read_bursts", rd_adr_q.size(), exp_adr.size());
      for (int i = 0; i < exp_adr.size() && i < rd_adr_q.size(); i++)
         check("read_adr", rd_adr_q[i], exp_adr[i]);
      for (int i = 0; i < rd_len_q.size(); i++)
         check("read_len", rd_len_q[i], RW);
      for (int i = 1; i < fs_q.size(); i++)
         check("byte_spacing", fs_q[i] - fs_q[i-1], BYTE_CYC);
      check("adr_stable_in_read", adr_unstable, 0);
      repeat (1 + tail) @(negedge clk);
      check("done_pulses", done_cnt - d0, 1);
      check("no_extra_reads", rd_adr_q.size(), exp_adr.size());
      $display("xfer %s first=%h last=%h bytes=%0d cycles=%0d", name, f, l, rx_q.size(), n + 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      logic [AW-1:0] rf;
      logic [AW-1:0] rl;
      int len;

      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_read", read, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_adr", adr, 0);
      n_reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);

      run_xfer(21'h00010, 21'h00010, "single", -1, 4);
      run_xfer(21'h1FFFE, 21'h20001, "range", -1, 4);
      run_xfer(ADR_MAX, ADR_MAX, "top", -1, 4);
      check("top_no_wrap", adr_zero_seen, 0);
      check("top_adr_held", adr, ADR_MAX);
      // Empty range; a second start lands in the FIN cycle and must be ignored.
      run_xfer(21'h00100, 21'h000FF, "empty", 0, RW + 6);
      check("empty_tx_idle", tx, 1);
      // start while busy is ignored; start the cycle after done is accepted.
      run_xfer(21'h00040, 21'h00041, "poke_busy", 60, 0);
      run_xfer(21'h0007F, 21'h00080, "restart", -1, 4);

      for (int it = 0; it < 6; it++) begin
         rf  = AW'($urandom_range(0, 32'h1FFFFF));
         len = $urandom_range(0, 3);
         if (rf > ADR_MAX - AW'(len)) rl = ADR_MAX;
         else rl = rf + AW'(len);
         if ($urandom_range(0, 4) == 0 && rf != '0) rl = rf - AW'(1);
         run_xfer(rf, rl, "random", -1, 4);
      end

      // Asynchronous reset in the middle of a frame.
      d0 = done_cnt;
      adr_first = 21'h00050;
      adr_last  = 21'h00053;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (tx !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("frame_began", tx, 0);
      @(posedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      check("async_rst_tx", tx, 1);
      check("async_rst_read", read, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      repeat (3) @(negedge clk);
      rx_q.delete();
      rd_adr_q.delete();
      n_reset = 1'b1;
      repeat (100) @(negedge clk);
      check("no_done_after_reset", done_cnt - d0, 0);
      check("no_bytes_after_reset", rx_q.size(), 0);
      check("no_reads_after_reset", rd_adr_q.size(), 0);
      check("tx_idle_after_reset", tx, 1);
      $display("xfer reset_mid_frame first=00050 last=00053 bytes=%0d", rx_q.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
